// File: rtl/student_tlul_arbiter.sv
// N-to-1 TL-UL host arbiter with an in-order response-routing FIFO; A and D paths are pass-through.
// Define STUDENT_TLUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module student_tlul_arbiter #(
  parameter int NUM            = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  tlul_pkg::tl_h2d_t [NUM-1:0]   tl_host_i,
  output tlul_pkg::tl_d2h_t [NUM-1:0]   tl_host_o,
  output tlul_pkg::tl_h2d_t             tl_device_o,
  input  tlul_pkg::tl_d2h_t             tl_device_i
);
  localparam int IW = $clog2(NUM);
  localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CW = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e        state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] arb_grant;
  logic [IW-1:0] gnt;
  logic [IW-1:0] head;
  logic [IW-1:0] fifo_q [MaxOutstanding];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, accept, pop, dev_a_valid, dev_d_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic tlul_pkg::tl_d2h_t host_rsp(input tlul_pkg::tl_d2h_t dev,
                                                 input logic a_rdy, input logic d_vld);
    tlul_pkg::tl_d2h_t r;
    r         = dev;
    r.a_ready = a_rdy;
    r.d_valid = d_vld;
    return r;
  endfunction

`ifdef STUDENT_TLUL_ARB_FIXED_PRIO_EN
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    arb_grant = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      if (tl_host_i[IW'(k)].a_valid) arb_grant = IW'(k);
    end
  end
`else
  logic [IW-1:0] rr_ptr_q;
  logic          rr_found;
  int            rr_idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    arb_grant = rr_ptr_q;
    rr_found  = 1'b0;
    rr_idx    = 0;
    for (int k = 0; k < NUM; k++) begin
      rr_idx = (int'(rr_ptr_q) + k) % NUM;
      if (!rr_found && tl_host_i[IW'(rr_idx)].a_valid) begin
        rr_found  = 1'b1;
        arb_grant = IW'(rr_idx);
      end
    end
  end
`endif

  // Reset forces the FIFO to look empty so outputs are defined while rst_i is held.
  assign empty       = (count_q == '0) | rst_i;
  assign full        = (count_q == CW'(MaxOutstanding)) & ~rst_i;
  assign gnt         = (state_q == HOLD) ? grant_q : arb_grant;
  assign dev_a_valid = tl_host_i[gnt].a_valid & ~full;
  assign accept      = dev_a_valid & tl_device_i.a_ready;
  assign head        = fifo_q[rd_ptr_q];
  assign dev_d_ready = empty ? 1'b1 : tl_host_i[head].d_ready;
  assign pop         = tl_device_i.d_valid & dev_d_ready & ~empty;

  always_comb begin
    tl_device_o         = tl_host_i[gnt];
    tl_device_o.a_valid = dev_a_valid;
    tl_device_o.d_ready = dev_d_ready;
  end

  for (genvar i = 0; i < NUM; i++) begin : g_host
    assign tl_host_o[i] = host_rsp(tl_device_i,
                                   dev_a_valid & tl_device_i.a_ready & (gnt == IW'(i)),
                                   tl_device_i.d_valid & ~empty & (head == IW'(i)));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
`ifndef STUDENT_TLUL_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (dev_a_valid && !tl_device_i.a_ready) begin
          state_q <= HOLD;
          grant_q <= arb_grant;
        end
        HOLD: if (accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
`ifndef STUDENT_TLUL_ARB_FIXED_PRIO_EN
      if (accept) rr_ptr_q <= (gnt == IW'(NUM - 1)) ? '0 : gnt + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; entries are only read below count_q, which is reset.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_q[wr_ptr_q] <= gnt;
  end

endmodule

// File: tb/tb_student_tlul_arbiter.sv
// Self-checking bench for student_tlul_arbiter: directed scenarios plus a randomized run
// compared against a queue-based reference model of arbitration and response routing.
module tb_student_tlul_arbiter;
  import tlul_pkg::*;

  localparam int NUM  = 2;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  tl_h2d_t [NUM-1:0] host_i;
  tl_d2h_t [NUM-1:0] host_o;
  tl_h2d_t           dev_o;
  tl_d2h_t           dev_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  student_tlul_arbiter #(.NUM(NUM), .MaxOutstanding(MAXO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tl_host_i   (host_i),
    .tl_host_o   (host_o),
    .tl_device_o (dev_o),
    .tl_device_i (dev_i)
  );

  task automatic drive_idle();
    host_i = '0;
    for (int i = 0; i < NUM; i++) host_i[i].d_ready = 1'b1;
    dev_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int phase = 0; phase < 2; phase++) begin
      @(negedge clk);
      rst = (phase == 0);
      drive_idle();
      @(negedge clk);
      #1;
      for (int i = 0; i < NUM; i++) begin
        n_checks++;
        if (host_o[i].a_ready !== 1'b0) begin
          n_errors++; $display("FAIL reset_a_ready[%0d] phase%0d: got %b want 0", i, phase, host_o[i].a_ready);
        end
        n_checks++;
        if (host_o[i].d_valid !== 1'b0) begin
          n_errors++; $display("FAIL reset_d_valid[%0d] phase%0d: got %b want 0", i, phase, host_o[i].d_valid);
        end
      end
      n_checks++;
      if (dev_o.a_valid !== 1'b0) begin
        n_errors++; $display("FAIL reset_dev_a_valid phase%0d: got %b want 0", phase, dev_o.a_valid);
      end
      n_checks++;
      if (dev_o.d_ready !== 1'b1) begin
        n_errors++; $display("FAIL reset_dev_d_ready phase%0d: got %b want 1", phase, dev_o.d_ready);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    host_i[0].a_valid   = 1'b1;
    host_i[0].a_opcode  = 3'd4;
    host_i[0].a_size    = 2'd2;
    host_i[0].a_mask    = 4'hF;
    host_i[0].a_source  = 8'h10;
    host_i[0].a_address = 32'h1000;
    dev_i.a_ready = 1'b1;
    #1;
    n_checks++;
    if (dev_o.a_valid !== 1'b1 || dev_o.a_address !== 32'h1000 || dev_o.a_source !== 8'h10) begin
      n_errors++; $display("FAIL single_a: got v=%b addr=%h src=%h want v=1 addr=00001000 src=10",
                           dev_o.a_valid, dev_o.a_address, dev_o.a_source);
    end
    n_checks++;
    if ({host_o[1].a_ready, host_o[0].a_ready} !== 2'b01) begin
      n_errors++; $display("FAIL single_a_ready: got %b want 01", {host_o[1].a_ready, host_o[0].a_ready});
    end
    @(negedge clk);
    host_i[0].a_valid = 1'b0;
    dev_i.d_valid  = 1'b1;
    dev_i.d_opcode = 3'd1;
    dev_i.d_source = 8'h10;
    dev_i.d_data   = 32'hCAFE0001;
    #1;
    n_checks++;
    if (host_o[0].d_valid !== 1'b1 || host_o[0].d_data !== 32'hCAFE0001) begin
      n_errors++; $display("FAIL single_d_host0: got v=%b data=%h want v=1 data=cafe0001",
                           host_o[0].d_valid, host_o[0].d_data);
    end
    n_checks++;
    if (host_o[1].d_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_d_host1: got %b want 0", host_o[1].d_valid);
    end
    @(negedge clk);
    dev_i.d_valid = 1'b0;
    #1;
    n_checks++;
    if (host_o[1].d_valid !== 1'b0 || dev_o.d_ready !== 1'b1) begin
      n_errors++; $display("FAIL single_after: got h1_dv=%b d_ready=%b want 0 1", host_o[1].d_valid, dev_o.d_ready);
    end
  endtask

  task automatic test_simultaneous();
    int exp;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      host_i[0].a_valid = 1'b1; host_i[0].a_address = 32'hA000;
      host_i[1].a_valid = 1'b1; host_i[1].a_address = 32'hB000;
      dev_i.a_ready = 1'b1;
`ifdef STUDENT_TLUL_ARB_FIXED_PRIO_EN
      exp = 0;
`else
      exp = c % 2;
`endif
      #1;
      n_checks++;
      if ({host_o[1].a_ready, host_o[0].a_ready} !== (2'b01 << exp)) begin
        n_errors++; $display("FAIL simul_grant c%0d: got %b want host%0d", c,
                             {host_o[1].a_ready, host_o[0].a_ready}, exp);
      end
      n_checks++;
      if (dev_o.a_address !== (exp == 1 ? 32'hB000 : 32'hA000)) begin
        n_errors++; $display("FAIL simul_addr c%0d: got %h want host%0d addr", c, dev_o.a_address, exp);
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      host_i[1].a_valid   = (c < 4);
      host_i[1].a_address = 32'h2000;
      host_i[0].a_valid   = (c >= 1);
      host_i[0].a_address = 32'h3000;
      dev_i.a_ready = (c >= 3);
      #1;
      if (c < 3) begin
        n_checks++;
        if (dev_o.a_valid !== 1'b1 || dev_o.a_address !== 32'h2000 ||
            {host_o[1].a_ready, host_o[0].a_ready} !== 2'b00) begin
          n_errors++; $display("FAIL bp_hold c%0d: got v=%b addr=%h rdy=%b want 1 00002000 00", c,
                               dev_o.a_valid, dev_o.a_address, {host_o[1].a_ready, host_o[0].a_ready});
        end
      end else if (c == 3) begin
        n_checks++;
        if (dev_o.a_address !== 32'h2000 || {host_o[1].a_ready, host_o[0].a_ready} !== 2'b10) begin
          n_errors++; $display("FAIL bp_accept_h1: got addr=%h rdy=%b want 00002000 10",
                               dev_o.a_address, {host_o[1].a_ready, host_o[0].a_ready});
        end
      end else begin
        n_checks++;
        if (dev_o.a_address !== 32'h3000 || {host_o[1].a_ready, host_o[0].a_ready} !== 2'b01) begin
          n_errors++; $display("FAIL bp_accept_h0: got addr=%h rdy=%b want 00003000 01",
                               dev_o.a_address, {host_o[1].a_ready, host_o[0].a_ready});
        end
      end
    end
  endtask

  task automatic test_full();
    int rem [NUM];
    int acc [$];
    int exp [5];
`ifdef STUDENT_TLUL_ARB_FIXED_PRIO_EN
    exp = '{0, 0, 0, 1, 1};
`else
    exp = '{0, 1, 0, 1, 0};
`endif
    rem[0] = 3; rem[1] = 2;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM; i++) begin
        host_i[i].a_valid   = (rem[i] > 0);
        host_i[i].a_address = 32'h4000 + 32'(i * 256 + rem[i]);
      end
      dev_i.a_ready = 1'b1;
      #1;
      if (c >= 4) begin
        n_checks++;
        if (dev_o.a_valid !== 1'b0) begin
          n_errors++; $display("FAIL full_a_valid c%0d: got %b want 0", c, dev_o.a_valid);
        end
      end
      for (int i = 0; i < NUM; i++)
        if (host_i[i].a_valid && host_o[i].a_ready) begin acc.push_back(i); rem[i]--; end
    end
    n_checks++;
    if (acc.size() != 4) begin
      n_errors++; $display("FAIL full_count: got %0d acceptances want 4", acc.size());
    end
    for (int k = 0; k < acc.size() && k < 4; k++) begin
      n_checks++;
      if (acc[k] != exp[k]) begin
        n_errors++; $display("FAIL full_order[%0d]: got host%0d want host%0d", k, acc[k], exp[k]);
      end
    end
    // One D beat completes while still full: A stays blocked this cycle.
    @(negedge clk);
    dev_i.d_valid = 1'b1; dev_i.d_data = 32'hD000_0000;
    #1;
    n_checks++;
    if (host_o[exp[0]].d_valid !== 1'b1 || host_o[1 - exp[0]].d_valid !== 1'b0 || dev_o.a_valid !== 1'b0) begin
      n_errors++; $display("FAIL full_first_d: got dv0=%b dv1=%b av=%b want host%0d only, av=0",
                           host_o[0].d_valid, host_o[1].d_valid, dev_o.a_valid, exp[0]);
    end
    @(negedge clk);
    dev_i.d_valid = 1'b0;
    for (int i = 0; i < NUM; i++) host_i[i].a_valid = (rem[i] > 0);
    #1;
    n_checks++;
    if (dev_o.a_valid !== 1'b1 || host_o[exp[4]].a_ready !== 1'b1) begin
      n_errors++; $display("FAIL full_fifth: got av=%b rdy=%b want 1 on host%0d", dev_o.a_valid,
                           {host_o[1].a_ready, host_o[0].a_ready}, exp[4]);
    end
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      host_i[0].a_valid = 1'b0; host_i[1].a_valid = 1'b0;
      dev_i.d_valid = 1'b1; dev_i.d_data = 32'hD000_0000 + 32'(k);
      #1;
      n_checks++;
      if ({host_o[1].d_valid, host_o[0].d_valid} !== (2'b01 << exp[k])) begin
        n_errors++; $display("FAIL full_resp[%0d]: got %b want host%0d", k,
                             {host_o[1].d_valid, host_o[0].d_valid}, exp[k]);
      end
    end
    @(negedge clk);
    dev_i.d_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      host_i[c].a_valid = 1'b1; host_i[1 - c].a_valid = 1'b0;
      dev_i.a_ready = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    host_i[0].d_ready = 1'b0; host_i[1].d_ready = 1'b0;
    dev_i.d_valid = 1'b1; dev_i.d_data = 32'hBAD0BAD0;
    #1;
    n_checks++;
    if (dev_o.d_ready !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_d_ready: got %b want 1", dev_o.d_ready);
    end
    n_checks++;
    if ({host_o[1].d_valid, host_o[0].d_valid} !== 2'b00) begin
      n_errors++; $display("FAIL rstmid_d_valid: got %b want 00", {host_o[1].d_valid, host_o[0].d_valid});
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_random();
    int          q [$];
    bit          pend [NUM];
    logic [31:0] addr [NUM];
    int          rr, g, head, idx, lock_host;
    bit          locked, full, evalid, eready, accept;
    do_reset();
    q = {}; rr = 0; locked = 0; lock_host = 0;
    for (int i = 0; i < NUM; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin pend[i] = 1; addr[i] = $urandom; end
        host_i[i].a_valid   = pend[i];
        host_i[i].a_address = addr[i];
        host_i[i].a_source  = 8'(i);
        host_i[i].d_ready   = ($urandom_range(0, 3) != 0);
      end
      dev_i.a_ready = $urandom_range(0, 1);
      dev_i.d_valid = ($urandom_range(0, 2) == 0);
      dev_i.d_data  = $urandom;
      #1;
      full = (q.size() == MAXO);
      g = -1;
      if (locked) g = lock_host;
      else
        for (int k = 0; k < NUM; k++) begin
`ifdef STUDENT_TLUL_ARB_FIXED_PRIO_EN
          idx = k;
`else
          idx = (rr + k) % NUM;
`endif
          if (g < 0 && pend[idx]) g = idx;
        end
      evalid = (g >= 0) && pend[g] && !full;
      head   = (q.size() > 0) ? q[0] : -1;
      eready = (head < 0) ? 1'b1 : host_i[head].d_ready;
      n_checks++;
      if (dev_o.a_valid !== evalid || (evalid && dev_o.a_address !== addr[g])) begin
        n_errors++; $display("FAIL rand_a c%0d: got v=%b addr=%h want v=%b host%0d", c,
                             dev_o.a_valid, dev_o.a_address, evalid, g);
      end
      n_checks++;
      if (dev_o.d_ready !== eready) begin
        n_errors++; $display("FAIL rand_d_ready c%0d: got %b want %b", c, dev_o.d_ready, eready);
      end
      for (int i = 0; i < NUM; i++) begin
        n_checks++;
        if (host_o[i].a_ready !== (evalid && g == i && dev_i.a_ready) ||
            host_o[i].d_valid !== (dev_i.d_valid && head == i) ||
            host_o[i].d_data !== dev_i.d_data) begin
          n_errors++; $display("FAIL rand_host%0d c%0d: got ar=%b dv=%b want ar=%b dv=%b", i, c,
                               host_o[i].a_ready, host_o[i].d_valid,
                               evalid && g == i && dev_i.a_ready, dev_i.d_valid && head == i);
        end
      end
      accept = evalid && dev_i.a_ready;
      if (evalid && !accept) begin locked = 1; lock_host = g; end
      if (head >= 0 && dev_i.d_valid && eready) void'(q.pop_front());
      if (accept) begin
        locked = 0;
        rr = (g + 1) % NUM;
        pend[g] = 0;
        q.push_back(g);
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_simultaneous();
    test_back_pressure();
    test_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/student_tlul_arbiter.md
# student_tlul_arbiter

N-to-1 TL-UL host arbiter: merges the A channels of `NUM` TL-UL hosts (DMA, debug/CPU bridges) onto one device port and routes each D-channel response back to the host that issued the request. It is the converging counterpart of `student_tlul_mux`, which fans one host out to many devices. It sits in `student` in front of a shared device port, for example the fast port when more than one master needs it. A/D paths are combinational pass-through, so the block adds no latency.

## Interface
- `NUM`, default 2, number of host ports (≥2); index width `IW = $clog2(NUM)`.
- `MaxOutstanding`, default 4, depth of the in-order response-routing FIFO (≥1).
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `tl_host_i`  in  `tlul_pkg::tl_h2d_t [NUM-1:0]`  A-channel requests and `d_ready` from the hosts.
- `tl_host_o`  out  `tlul_pkg::tl_d2h_t [NUM-1:0]`  `a_ready` and D-channel responses to the hosts.
- `tl_device_o`  out  `tlul_pkg::tl_h2d_t`  merged A channel toward the device.
- `tl_device_i`  in  `tlul_pkg::tl_d2h_t`  device `a_ready` and D channel.

## Operation
- State machine, two states:
  - **IDLE**: the grant is computed combinationally among hosts with `a_valid`, round-robin starting at `rr_ptr`.
  - **HOLD**: the grant is latched in `grant_q`. It is entered when the granted beat is presented but not accepted.
- HOLD returns to IDLE on acceptance.
- Acceptance: `tl_device_o.a_valid & tl_device_i.a_ready`.
- A channel:
  - `tl_device_o` carries all A fields of the granted host unchanged; `a_source` is not rewritten.
  - `tl_device_o.a_valid = granted.a_valid & !full`.
  - `tl_host_o[g].a_ready = tl_device_i.a_ready & !full` for the granted host `g`; every other host sees `a_ready = 0`.
- On acceptance:
  - push `g` into the routing FIFO;
  - `rr_ptr <= (g+1) mod NUM`.
- Full: count == `MaxOutstanding`. No A beat is presented, so `a_valid` is never raised and then withdrawn.
- D channel:
  - The FIFO head `h` selects the target. `tl_host_o[h].d_valid = tl_device_i.d_valid`.
  - D fields are broadcast to all hosts; `d_valid = 0` for non-head hosts.
  - `tl_device_o.d_ready = tl_host_i[h].d_ready`.
  - A completed D beat (`d_valid & d_ready`) pops the FIFO.
- Empty FIFO with `tl_device_i.d_valid = 1` is a protocol violation:
  - `tl_device_o.d_ready = 1` and the beat is discarded;
  - no host sees `d_valid`.
- Push and pop in the same cycle: count unchanged, and the head advances correctly, including when depth is 1.
- FIFO pointers wrap modulo `MaxOutstanding`; count is `$clog2(MaxOutstanding+1)` bits.
- The device must respond in order. This holds for every device behind `student_tlul_mux`.

## Timing
- A and D paths have zero-cycle latency; acceptance by the device in the request cycle is a single-cycle transfer.
- Grant, FIFO and `rr_ptr` update on the clock edge following acceptance or completion.
- HOLD keeps `g` stable until acceptance, even if a higher-priority host raises `a_valid` meanwhile.
- Reset (any cycle, including mid-transaction):
  - state returns to IDLE, `rr_ptr = 0`, FIFO is emptied;
  - in-flight responses are discarded.
- Output values during and right after reset, until a host drives `a_valid`:
  - all `tl_host_o[*].a_ready = 0` and `tl_host_o[*].d_valid = 0`;
  - `tl_device_o.a_valid = 0`; `tl_device_o.d_ready = 1` (empty FIFO).

## Configuration
- `STUDENT_TLUL_ARB_FIXED_PRIO_EN`
  - **Defined**: fixed priority, lowest host index wins; `rr_ptr` is not implemented.
  - **Undefined** (default): round-robin as described.
- HOLD locking, FIFO routing and reset behaviour are identical in both builds.

## Test plan
- **Single host, no contention**: host0 issues Get to 0x1000; device `a_ready = 1` and returns `d_data = 0xCAFE0001` one cycle later. Required: host0 receives 0xCAFE0001; host1 never sees `d_valid`.
- **Simultaneous requests**: both hosts raise `a_valid` in cycle 0; device always ready. Required:
  - round-robin build: order host0, host1, host0, host1 over 4 back-to-back requests;
  - FIXED_PRIO build: host0 is served until it drops `a_valid`.
- **Back-pressure**: device holds `a_ready = 0` for 3 cycles while host1 is granted and host0 raises `a_valid`. Required: `tl_device_o` fields stay equal to host1's for all 3 cycles; host1 is accepted on cycle 4, then host0.
- **Full FIFO**: `MaxOutstanding = 4`, device withholds D; hosts issue 5 requests. Required: exactly 4 acceptances and `tl_device_o.a_valid = 0` on the 5th. After one D beat completes, the 5th request is accepted the next cycle; responses reach the hosts in acceptance order.
- **Reset mid-operation**: assert `rst_i` for 1 cycle with 2 requests outstanding. Required: the FIFO is empty afterwards; a subsequent stray device `d_valid` is absorbed (`d_ready = 1`) and no host sees it.
